interrupt_sequencer: RTL

- Controller that sequences the 6502 datapath through the 7-cycle interrupt/reset entry: two internal cycles, three stack pushes (PCH, PCL, P), then a two-byte vector fetch.
- Arbitrates RESET, NMI, BRK and IRQ at instruction boundaries.
- While active, drives the stack/vector address selects, bus-latch enables and flag updates instead of the main opcode decoder.
- Sits beside the main control FSM; the main FSM yields whenever `take_over` is high.

---
 rtl/hmc6502_pkg.sv | 36 +++
 rtl/nmi_edge_detect.sv | 29 ++
 rtl/interrupt_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hmc6502_pkg.sv
// Shared types and constants for the hmc6502 control path.
// Interrupt-sequencer states, source encoding, select encodings and vector bytes.
package hmc6502_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StRstIdle,
    StInt1,
    StInt2,
    StPushPch,
    StPushPcl,
    StPushP,
    StVecLo,
    StVecHi
  } int_state_t;

  typedef enum logic [1:0] {
    SRC_RST,
    SRC_NMI,
    SRC_BRK,
    SRC_IRQ
  } int_src_t;

  localparam logic [1:0] AddrNone   = 2'd0;
  localparam logic [1:0] AddrStack  = 2'd1;
  localparam logic [1:0] AddrVector = 2'd2;

  localparam logic [1:0] PushPch = 2'd0;
  localparam logic [1:0] PushPcl = 2'd1;
  localparam logic [1:0] PushP   = 2'd2;

  localparam logic [7:0] NmiVecLoDflt = 8'hFA;
  localparam logic [7:0] RstVecLoDflt = 8'hFC;
  localparam logic [7:0] IrqVecLoDflt = 8'hFE;

endpackage

// File: rtl/nmi_edge_detect.sv
// NMI falling-edge detector with a pending flag.
// A fall in the same cycle as a clear keeps the flag set.
module nmi_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic nmi_n_i,
  input  logic clr_i,
  output logic set_o,
  output logic pend_o
);

  logic prev_q;
  logic pend_q, pend_d;

  assign set_o  = prev_q & ~nmi_n_i;
  assign pend_d = set_o | (pend_q & ~clr_i);
  assign pend_o = pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      prev_q <= nmi_n_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/reset entry sequencer: arbitrates RESET/NMI/BRK/IRQ at instruction
// boundaries and drives the 7-cycle stack-push / vector-fetch sequence.
module interrupt_sequencer
  import hmc6502_pkg::*;
#(
  parameter logic [7:0] NMI_VEC_LO = NmiVecLoDflt,
  parameter logic [7:0] RST_VEC_LO = RstVecLoDflt,
  parameter logic [7:0] IRQ_VEC_LO = IrqVecLoDflt
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nmi_n_i,
  input  logic       irq_n_i,
  input  logic       brk_req_i,
  input  logic       instr_boundary_i,
  input  logic       i_flag_i,
  input  logic       ready_i,
  output logic       take_over_o,
  output logic [1:0] addr_sel_o,
  output logic [7:0] vector_lo_o,
  output logic [1:0] push_sel_o,
  output logic       mem_write_o,
  output logic       sp_dec_o,
  output logic       pcl_load_o,
  output logic       pch_load_o,
  output logic       set_i_o,
  output logic       b_value_o,
  output logic       done_o
);

  int_state_t state_q, state_d;
  int_src_t   src_q, src_d;
  logic       rst_pend_q, rst_clr;
  logic       use_nmi_q, use_nmi_d;
  logic       nmi_set, nmi_pend, nmi_clr;
  logic       arb_valid;
  int_src_t   arb_src;
  logic       push_go;
  logic [7:0] vec_base;

  nmi_edge_detect u_nmi_edge_detect (
    .clk     (clk),
    .reset   (reset),
    .nmi_n_i (nmi_n_i),
    .clr_i   (nmi_clr),
    .set_o   (nmi_set),
    .pend_o  (nmi_pend)
  );

  always_comb begin
    arb_valid = 1'b1;
    arb_src   = SRC_RST;
    if (rst_pend_q)                    arb_src = SRC_RST;
    else if (nmi_pend)                 arb_src = SRC_NMI;
    else if (brk_req_i)                arb_src = SRC_BRK;
    else if (!irq_n_i && !i_flag_i)    arb_src = SRC_IRQ;
    else                               arb_valid = 1'b0;
  end

  assign vec_base = (src_q == SRC_RST) ? RST_VEC_LO :
                    use_nmi_q          ? NMI_VEC_LO : IRQ_VEC_LO;
  // Reset pushes are reads and stall on RDY; real pushes are writes and never stall.
  assign push_go  = ready_i || (src_q != SRC_RST);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    use_nmi_d   = use_nmi_q;
    nmi_clr     = 1'b0;
    rst_clr     = 1'b0;
    take_over_o = 1'b0;
    addr_sel_o  = AddrNone;
    vector_lo_o = 8'h00;
    push_sel_o  = PushPch;
    mem_write_o = 1'b0;
    sp_dec_o    = 1'b0;
    pcl_load_o  = 1'b0;
    pch_load_o  = 1'b0;
    set_i_o     = 1'b0;
    b_value_o   = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      StIdle, StRstIdle: begin
        if ((instr_boundary_i || state_q == StRstIdle) && arb_valid) begin
          state_d   = StInt1;
          src_d     = arb_src;
          use_nmi_d = (arb_src == SRC_NMI);
        end
      end
      StInt1: begin
        take_over_o = 1'b1;
        if (ready_i) state_d = StInt2;
      end
      StInt2: begin
        take_over_o = 1'b1;
        if (ready_i) state_d = StPushPch;
      end
      StPushPch, StPushPcl, StPushP: begin
        take_over_o = 1'b1;
        addr_sel_o  = AddrStack;
        mem_write_o = (src_q != SRC_RST);
        sp_dec_o    = push_go;
        push_sel_o  = (state_q == StPushPch) ? PushPch :
                      (state_q == StPushPcl) ? PushPcl : PushP;
        if (state_q == StPushP) b_value_o = (src_q == SRC_BRK);
        if (push_go) begin
          if (state_q == StPushPch)      state_d = StPushPcl;
          else if (state_q == StPushPcl) state_d = StPushP;
          else begin
            state_d = StVecLo;
            // Late NMI hijacks a BRK/IRQ entry; decision frozen here for both vector bytes.
            if ((src_q == SRC_BRK || src_q == SRC_IRQ) && (nmi_pend || nmi_set))
              use_nmi_d = 1'b1;
          end
        end
      end
      StVecLo: begin
        take_over_o = 1'b1;
        addr_sel_o  = AddrVector;
        vector_lo_o = vec_base;
        if (ready_i) begin
          pcl_load_o = 1'b1;
          set_i_o    = 1'b1;
          nmi_clr    = use_nmi_q;
          rst_clr    = (src_q == SRC_RST);
          state_d    = StVecHi;
        end
      end
      StVecHi: begin
        take_over_o = 1'b1;
        addr_sel_o  = AddrVector;
        vector_lo_o = vec_base + 8'd1;
        if (ready_i) begin
          pch_load_o = 1'b1;
          done_o     = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (reset) begin
      take_over_o = 1'b0;
      addr_sel_o  = AddrNone;
      vector_lo_o = 8'h00;
      push_sel_o  = PushPch;
      mem_write_o = 1'b0;
      sp_dec_o    = 1'b0;
      pcl_load_o  = 1'b0;
      pch_load_o  = 1'b0;
      set_i_o     = 1'b0;
      b_value_o   = 1'b0;
      done_o      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRstIdle;
      src_q      <= SRC_RST;
      rst_pend_q <= 1'b1;
      use_nmi_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      use_nmi_q  <= use_nmi_d;
      if (rst_clr) rst_pend_q <= 1'b0;
    end
  end

endmodule
